vvctrl_instr_encoder: RTL

Instruction issuer for the VV engine: the encoder-side counterpart of vvctrl_instruction_decoder/vvctrl_blkSignalGen.
- Accepts field-level requests (opcode, addr, data, rs1, rs2, id, actcode) over a valid/ready handshake.
- Packs each request into one instruction word and drives it to vvctrl_blkSignalGen.
- Pads with NOP words for idle cycles and for per-request wait gaps.
- Sits between the host/sequencer and the vvcontroller instruction input.

---
 rtl/vvctrl_instr_encoder_pkg.sv | 90 +++++++++
 rtl/vvctrl_instr_pack.sv | 37 +++
 rtl/vvctrl_instruction_decoder.sv | 24 ++
 rtl/vvctrl_instr_encoder.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/vvctrl_instr_encoder_pkg.sv
// Shared definitions for the VV instruction encoder: field widths and bit
// positions of the instruction word, opcode set, encoder state enum,
// per-opcode field-usage masks and the NOP word.
package vvctrl_instr_encoder_pkg;

  // Field widths
  localparam int VVCTRL_OPCODE_WIDTH     = 4;
  localparam int RF_ADDR_WIDTH           = 4;
  localparam int VVENG_RF_WIDTH          = 8;
  localparam int VVCTRL_INSTR_RS_WIDTH   = 2;
  localparam int VVENG_ID_WIDTH          = 4;
  localparam int VV_ACTCODE_WIDTH        = 2;
  localparam int VVENG_INSTRUCTION_WIDTH = 26;

  // Field LSB positions, identical to what the downstream decoder extracts
  localparam int OPCODE_LSB = 0;
  localparam int ADDR_LSB   = 4;
  localparam int DATA_LSB   = 8;
  localparam int RS1_LSB    = 16;
  localparam int RS2_LSB    = 18;
  localparam int ID_LSB     = 20;
  localparam int ACT_LSB    = 24;

  typedef enum logic [VVCTRL_OPCODE_WIDTH-1:0] {
    VVCTRL_NOP       = 4'd0,
    VVCTRL_WRITE0    = 4'd1,
    VVCTRL_WRITE1    = 4'd2,
    VVCTRL_ADD_XY    = 4'd3,
    VVCTRL_SUB_XY    = 4'd4,
    VVCTRL_MULT_XY   = 4'd5,
    VVCTRL_SELECTBLK = 4'd6,
    VVCTRL_ACTIVATE  = 4'd7
  } vvctrl_opcode_e;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } enc_state_e;

  // Which request fields an opcode carries into the word
  typedef struct packed {
    logic addr;
    logic data;
    logic rs1;
    logic rs2;
    logic id;
    logic act;
  } field_use_t;

  typedef struct packed {
    logic       supported;
    field_use_t fields;
  } op_info_t;

  typedef struct packed {
    logic [VVCTRL_OPCODE_WIDTH-1:0]   opcode;
    logic [RF_ADDR_WIDTH-1:0]         addr;
    logic [VVENG_RF_WIDTH-1:0]        data;
    logic [VVCTRL_INSTR_RS_WIDTH-1:0] rs1;
    logic [VVCTRL_INSTR_RS_WIDTH-1:0] rs2;
    logic [VVENG_ID_WIDTH-1:0]        id;
    logic [VV_ACTCODE_WIDTH-1:0]      act;
  } req_fields_t;

  localparam field_use_t USE_NONE   = '{default: 1'b0};
  localparam field_use_t USE_WRITE  = '{addr: 1'b1, data: 1'b1, default: 1'b0};
  localparam field_use_t USE_ALU    = '{addr: 1'b1, rs1: 1'b1, rs2: 1'b1, default: 1'b0};
  localparam field_use_t USE_SELBLK = '{id: 1'b1, default: 1'b0};
  localparam field_use_t USE_ACT    = '{addr: 1'b1, act: 1'b1, default: 1'b0};

  localparam logic [VVENG_INSTRUCTION_WIDTH-1:0] NOP_WORD =
    VVENG_INSTRUCTION_WIDTH'(VVCTRL_NOP);

  // Opcode lookup: support flag plus the fields the opcode uses
  function automatic op_info_t opInfo(input logic [VVCTRL_OPCODE_WIDTH-1:0] op);
    op_info_t info;
    info.supported = 1'b1;
    info.fields    = USE_NONE;
    case (op)
      VVCTRL_NOP:                                      info.fields = USE_NONE;
      VVCTRL_WRITE0, VVCTRL_WRITE1:                    info.fields = USE_WRITE;
      VVCTRL_ADD_XY, VVCTRL_SUB_XY, VVCTRL_MULT_XY:    info.fields = USE_ALU;
      VVCTRL_SELECTBLK:                                info.fields = USE_SELBLK;
      VVCTRL_ACTIVATE:                                 info.fields = USE_ACT;
      default:                                         info.supported = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/vvctrl_instr_pack.sv
// Combinational packer: places the request fields used by the opcode into
// one instruction word; unused bits stay 0. Unsupported opcodes yield the
// NOP word and raise badOp.
module vvctrl_instr_pack
  import vvctrl_instr_encoder_pkg::*;
(
  input  logic [VVCTRL_OPCODE_WIDTH-1:0]     opcode,
  input  logic [RF_ADDR_WIDTH-1:0]           addr,
  input  logic [VVENG_RF_WIDTH-1:0]          data,
  input  logic [VVCTRL_INSTR_RS_WIDTH-1:0]   rs1,
  input  logic [VVCTRL_INSTR_RS_WIDTH-1:0]   rs2,
  input  logic [VVENG_ID_WIDTH-1:0]          id,
  input  logic [VV_ACTCODE_WIDTH-1:0]        actcode,
  output logic [VVENG_INSTRUCTION_WIDTH-1:0] word,
  output logic                               badOp
);

  op_info_t info;

  // Build the word field by field according to the opcode's usage mask
  always_comb begin
    // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
    info  = opInfo(opcode);
    word  = NOP_WORD;
    badOp = !info.supported;
    if (info.supported) begin
      word[OPCODE_LSB +: VVCTRL_OPCODE_WIDTH] = opcode;
      if (info.fields.addr) word[ADDR_LSB +: RF_ADDR_WIDTH]         = addr;
      if (info.fields.data) word[DATA_LSB +: VVENG_RF_WIDTH]        = data;
      if (info.fields.rs1)  word[RS1_LSB  +: VVCTRL_INSTR_RS_WIDTH] = rs1;
      if (info.fields.rs2)  word[RS2_LSB  +: VVCTRL_INSTR_RS_WIDTH] = rs2;
      if (info.fields.id)   word[ID_LSB   +: VVENG_ID_WIDTH]        = id;
      if (info.fields.act)  word[ACT_LSB  +: VV_ACTCODE_WIDTH]      = actcode;
    end
  end

endmodule

// File: rtl/vvctrl_instruction_decoder.sv
// Field extractor for the VV instruction word; the same view of the word
// that vvctrl_blkSignalGen consumes. Used by the encoder self-check build.
module vvctrl_instruction_decoder
  import vvctrl_instr_encoder_pkg::*;
(
  input  logic [VVENG_INSTRUCTION_WIDTH-1:0] instruction,
  output logic [VVCTRL_OPCODE_WIDTH-1:0]     opcode,
  output logic [RF_ADDR_WIDTH-1:0]           addr,
  output logic [VVENG_RF_WIDTH-1:0]          data,
  output logic [VVCTRL_INSTR_RS_WIDTH-1:0]   rs1,
  output logic [VVCTRL_INSTR_RS_WIDTH-1:0]   rs2,
  output logic [VVENG_ID_WIDTH-1:0]          id,
  output logic [VV_ACTCODE_WIDTH-1:0]        actcode
);

  assign opcode  = instruction[OPCODE_LSB +: VVCTRL_OPCODE_WIDTH];
  assign addr    = instruction[ADDR_LSB   +: RF_ADDR_WIDTH];
  assign data    = instruction[DATA_LSB   +: VVENG_RF_WIDTH];
  assign rs1     = instruction[RS1_LSB    +: VVCTRL_INSTR_RS_WIDTH];
  assign rs2     = instruction[RS2_LSB    +: VVCTRL_INSTR_RS_WIDTH];
  assign id      = instruction[ID_LSB     +: VVENG_ID_WIDTH];
  assign actcode = instruction[ACT_LSB    +: VV_ACTCODE_WIDTH];

endmodule

// File: rtl/vvctrl_instr_encoder.sv
// VV engine instruction issuer. Accepts field-level requests over
// valid/ready, registers one packed instruction word per accept, and pads
// idle cycles and per-request gaps with NOP words.
// Optional: `define VVCTRL_ENC_SELFCHECK_EN to decode the issued word and
// flag any mismatch against the accepted request on selfcheck_err.
module vvctrl_instr_encoder
  import vvctrl_instr_encoder_pkg::*;
#(
  parameter int WAIT_WIDTH = 4,
  parameter int AUTO_GAP   = 0,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                               clk,
  input  logic                               rstn,
  input  logic                               req_valid,
  output logic                               req_ready,
  input  logic [VVCTRL_OPCODE_WIDTH-1:0]     req_opcode,
  input  logic [RF_ADDR_WIDTH-1:0]           req_addr,
  input  logic [VVENG_RF_WIDTH-1:0]          req_data,
  input  logic [VVCTRL_INSTR_RS_WIDTH-1:0]   req_rs1,
  input  logic [VVCTRL_INSTR_RS_WIDTH-1:0]   req_rs2,
  input  logic [VVENG_ID_WIDTH-1:0]          req_id,
  input  logic [VV_ACTCODE_WIDTH-1:0]        req_actcode,
  input  logic [WAIT_WIDTH-1:0]              req_wait,
  output logic [VVENG_INSTRUCTION_WIDTH-1:0] instruction,
  output logic                               instr_valid,
  output logic [CNT_WIDTH-1:0]               instr_count,
  output logic                               err_badop,
  input  logic                               dbg_clk_enable
`ifdef VVCTRL_ENC_SELFCHECK_EN
  ,
  output logic                               selfcheck_err
`endif
);

  localparam logic [WAIT_WIDTH-1:0] AUTO_GAP_W = WAIT_WIDTH'(AUTO_GAP);

  enc_state_e                       state, stateNext;
  logic [WAIT_WIDTH-1:0]            waitCnt, waitCntNext;
  logic [WAIT_WIDTH-1:0]            gap;
  logic                             accept;
  logic [VVENG_INSTRUCTION_WIDTH-1:0] packedWord;
  logic                             packedBad;

  // Ready depends on state and stepping only, never on req_valid
  assign req_ready = (state == IDLE) && dbg_clk_enable && rstn;
  assign accept    = req_valid && req_ready;
  assign gap       = (req_wait > AUTO_GAP_W) ? req_wait : AUTO_GAP_W;

  vvctrl_instr_pack u_pack (
    .opcode  (req_opcode),
    .addr    (req_addr),
    .data    (req_data),
    .rs1     (req_rs1),
    .rs2     (req_rs2),
    .id      (req_id),
    .actcode (req_actcode),
    .word    (packedWord),
    .badOp   (packedBad)
  );

  // Next state: WAIT holds for the issue cycle plus G padding cycles; frozen while stepping is off
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    if (dbg_clk_enable) begin
      case (state)
        IDLE: begin
          if (accept && (gap != '0)) begin
            stateNext   = WAIT;
            waitCntNext = gap;
          end
        end
        WAIT: begin
          if (waitCnt == '0) stateNext = IDLE;
          else               waitCntNext = waitCnt - WAIT_WIDTH'(1);
        end
        default: stateNext = IDLE;
      endcase
    end
  end

  // State register and wait counter
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: async reset is sampled on the negedge of rstn; state uses non-blocking assignments so all flops update together.
    if (!rstn) begin
      state   <= IDLE;
      waitCnt <= '0;
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
    end
  end

  // Output word register: encoded word on accept, NOP otherwise, plus issue count and sticky bad-op
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      instruction <= NOP_WORD;
      instr_valid <= 1'b0;
      instr_count <= '0;
      err_badop   <= 1'b0;
    end else begin
      instruction <= accept ? packedWord : NOP_WORD;
      instr_valid <= accept;
      if (accept)              instr_count <= instr_count + CNT_WIDTH'(1);
      if (accept && packedBad) err_badop   <= 1'b1;
    end
  end

`ifdef VVCTRL_ENC_SELFCHECK_EN
  req_fields_t                      reqQ;
  op_info_t                         chkInfo;
  logic                             mismatch;
  logic [VVCTRL_OPCODE_WIDTH-1:0]   decOpcode;
  logic [RF_ADDR_WIDTH-1:0]         decAddr;
  logic [VVENG_RF_WIDTH-1:0]        decData;
  logic [VVCTRL_INSTR_RS_WIDTH-1:0] decRs1;
  logic [VVCTRL_INSTR_RS_WIDTH-1:0] decRs2;
  logic [VVENG_ID_WIDTH-1:0]        decId;
  logic [VV_ACTCODE_WIDTH-1:0]      decAct;

  vvctrl_instruction_decoder u_decoder (
    .instruction (instruction),
    .opcode      (decOpcode),
    .addr        (decAddr),
    .data        (decData),
    .rs1         (decRs1),
    .rs2         (decRs2),
    .id          (decId),
    .actcode     (decAct)
  );

  // Copy of the accepted request, aligned with the registered word
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) reqQ <= '0;
    else if (accept) reqQ <= '{opcode: req_opcode, addr: req_addr, data: req_data,
                               rs1: req_rs1, rs2: req_rs2, id: req_id, act: req_actcode};
  end

  // Compare only the fields the issued opcode carries; bad opcodes must decode as NOP
  always_comb begin
    chkInfo  = opInfo(reqQ.opcode);
    mismatch = 1'b0;
    if (chkInfo.supported) begin
      if (decOpcode != reqQ.opcode)                      mismatch = 1'b1;
      if (chkInfo.fields.addr && (decAddr != reqQ.addr)) mismatch = 1'b1;
      if (chkInfo.fields.data && (decData != reqQ.data)) mismatch = 1'b1;
      if (chkInfo.fields.rs1  && (decRs1  != reqQ.rs1))  mismatch = 1'b1;
      if (chkInfo.fields.rs2  && (decRs2  != reqQ.rs2))  mismatch = 1'b1;
      if (chkInfo.fields.id   && (decId   != reqQ.id))   mismatch = 1'b1;
      if (chkInfo.fields.act  && (decAct  != reqQ.act))  mismatch = 1'b1;
    end else if (decOpcode != VVCTRL_NOP) begin
      mismatch = 1'b1;
    end
  end

  // Sticky self-check error
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) selfcheck_err <= 1'b0;
    else if (instr_valid && mismatch) selfcheck_err <= 1'b1;
  end
`endif

endmodule
